// File: rtl/result_pager.sv
// Holds a 64-bit result and shows it on a 32-bit display port, alternating high and low halves
// at a fixed page period. A new result is accepted only after the low half has been shown in full.
module result_pager #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned PAGE_MS       = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        hold,
  output logic [31:0] data,
  output logic        en,
  output logic        page
);

  localparam int unsigned PageCycles = CLK_FREQUENCY / 1000 * PAGE_MS;
  localparam int unsigned TimerW     = $clog2(PageCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(PageCycles - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHi   = 2'd1;
  localparam logic [1:0] StLo   = 2'd2;

  logic [63:0]       buf_q, buf_d;
  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              shown_q, shown_d;
  logic              accept;

  assign in_ready = (state_q == StIdle) | shown_q;
  assign accept   = in_valid & in_ready;

  // Accept has priority over both paging and hold.
  always_comb begin
    buf_d   = buf_q;
    state_d = state_q;
    timer_d = timer_q;
    shown_d = shown_q;
    if (accept) begin
      buf_d   = in_data;
      state_d = StHi;
      timer_d = '0;
      shown_d = 1'b0;
    end else if (!hold && (state_q == StHi || state_q == StLo)) begin
      if (timer_q == TimerLast) begin
        timer_d = '0;
        if (state_q == StHi) begin
          state_d = StLo;
        end else begin
          state_d = StHi;
          shown_d = 1'b1;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q   <= '0;
      state_q <= StIdle;
      timer_q <= '0;
      shown_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      state_q <= state_d;
      timer_q <= timer_d;
      shown_q <= shown_d;
    end
  end

  always_comb begin
    data = '0;
    en   = 1'b0;
    page = 1'b0;
    case (state_q)
      StHi: begin
        data = buf_q[63:32];
        en   = 1'b1;
      end
      StLo: begin
        data = buf_q[31:0];
        en   = 1'b1;
        page = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
